// File: rtl/led_scanner_multi.sv
// Multi-mode LED scanner: prescaled step engine driving a WIDTH-bit LED bank
// in bounce, comet, wrap-chase or bar-fill pattern.
module led_scanner_multi #(
    parameter int WIDTH   = 8,
    parameter int TICKDIV = 25000000,
    parameter int TRAIL   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [1:0]               speed,
    output logic [WIDTH-1:0]         dataOut,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     dir,
    output logic                     tick
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
    localparam logic [31:0]   DIV     = 32'(TICKDIV);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_COMET  = 2'b01,
        MODE_WRAP   = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    // Step period for a speed setting, saturated at one cycle.
    function automatic logic [31:0] sat_limit(input logic [1:0] sp);
        logic [31:0] lim;
        lim = DIV >> sp;
        if (lim == 32'd0) begin
            lim = 32'd1;
        end
        return lim;
    endfunction

    mode_t       mode_sel;
    logic [31:0] counter;
    logic [31:0] limit;
    logic        step_due;
    logic [PW-1:0] pos_nxt;
    logic          dir_nxt;

    assign mode_sel = mode_t'(mode);
    assign limit    = sat_limit(speed);
    // >= rather than == so a shrinking limit never lets the counter run away.
    assign step_due = en && (counter >= limit - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= 32'd0;
            pos     <= '0;
            dir     <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= step_due;
            if (en) begin
                if (step_due) begin
                    counter <= 32'd0;
                    pos     <= pos_nxt;
                    dir     <= dir_nxt;
                end else begin
                    counter <= counter + 32'd1;
                end
            end
        end
    end

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (mode_sel == MODE_WRAP) begin
            dir_nxt = 1'b0;
            pos_nxt = (pos == POS_MAX) ? '0 : pos + PW'(1);
        end else if (!dir && pos == POS_MAX) begin
            dir_nxt = 1'b1;
            pos_nxt = POS_MAX - PW'(1);
        end else if (dir && pos == '0) begin
            dir_nxt = 1'b0;
            pos_nxt = PW'(1);
        end else if (!dir) begin
            pos_nxt = pos + PW'(1);
        end else begin
            pos_nxt = pos - PW'(1);
        end
    end

    // Signed index math keeps the clipped comet tail free of wrap-around.
    always_comb begin
        int signed head;
        logic      lit;
        dataOut = '0;
        head    = int'(pos);
        for (int i = 0; i < WIDTH; i++) begin
            lit = 1'b0;
            case (mode_sel)
                MODE_COMET: lit = (i == head)
                               || (!dir && i < head && i >= head - TRAIL)
                               || ( dir && i > head && i <= head + TRAIL);
                MODE_FILL:  lit = (i <= head);
                default:    lit = (i == head);
            endcase
            dataOut[i] = lit;
        end
    end

endmodule

// File: tb/tb_led_scanner_multi.sv
// Directed bench for led_scanner_multi: main 8-LED instance plus TRAIL=0,
// WIDTH=2 and WIDTH=16 variants sharing the same stimulus.
module tb_led_scanner_multi;

    logic clk, rst, en;
    logic [1:0] mode, speed;

    logic [7:0]  data8, data8t;
    logic [2:0]  pos8, pos8t;
    logic        dir8, dir8t, tick8, tick8t;
    logic [1:0]  data2;
    logic        pos2, dir2, tick2;
    logic [15:0] data16;
    logic [3:0]  pos16;
    logic        dir16, tick16;

    int checks = 0;
    int failures = 0;

    led_scanner_multi #(.WIDTH(8), .TICKDIV(4), .TRAIL(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
        .dataOut(data8), .pos(pos8), .dir(dir8), .tick(tick8));

    led_scanner_multi #(.WIDTH(8), .TICKDIV(4), .TRAIL(0)) dut_t0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
        .dataOut(data8t), .pos(pos8t), .dir(dir8t), .tick(tick8t));

    led_scanner_multi #(.WIDTH(2), .TICKDIV(4), .TRAIL(2)) dut_w2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
        .dataOut(data2), .pos(pos2), .dir(dir2), .tick(tick2));

    led_scanner_multi #(.WIDTH(16), .TICKDIV(4), .TRAIL(2)) dut_w16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
        .dataOut(data16), .pos(pos16), .dir(dir16), .tick(tick16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] bounce_tbl [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] comet_tbl  [13] = '{8'h70, 8'hE0, 8'hC0, 8'hE0, 8'h70, 8'h38, 8'h1C,
                                    8'h0E, 8'h07, 8'h03, 8'h07, 8'h0E, 8'h1C};
    logic [2:0] comet_pos  [13] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2,
                                    3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic       comet_dir  [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] fill_tbl   [11] = '{8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F,
                                    8'h07, 8'h03, 8'h01, 8'h03};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    // Advance until the main instance pulses tick (bounded) and check the spacing.
    task automatic run_step(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            clk1();
            n++;
        end while (tick8 !== 1'b1 && n < 50);
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b00; speed = 2'b00;
        clk1();
        clk1();
        check("rst_data8", 32'(data8), 32'h01);
        check("rst_pos8", 32'(pos8), 32'd0);
        check("rst_dir8", 32'(dir8), 32'd0);
        check("rst_tick8", 32'(tick8), 32'd0);
        check("rst_data2", 32'(data2), 32'h1);
        check("rst_pos2", 32'(pos2), 32'd0);
        check("rst_data16", 32'(data16), 32'h0001);
        check("rst_pos16", 32'(pos16), 32'd0);
        check("rst_dir16", 32'(dir16), 32'd0);

        // Bounce at full period, all widths in lock-step
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            run_step("bounce_gap", 4);
            check("bounce_data8", 32'(data8), 32'(bounce_tbl[k]));
            check("bounce_dir8", 32'(dir8), (k < 7) ? 32'd0 : 32'd1);
            check("bounce_data16", 32'(data16), 32'h1 << (k + 1));
            check("bounce_data2", 32'(data2), (k % 2 == 0) ? 32'h2 : 32'h1);
            check("bounce_tick2", 32'(tick2), 32'd1);
            check("bounce_tick16", 32'(tick16), 32'd1);
        end

        // Speed changes
        speed = 2'd2;
        clk1();
        check("fast_tick_a", 32'(tick8), 32'd1);
        check("fast_data_a", 32'(data8), 32'h02);
        check("w16_top", 32'(data16), 32'h8000);
        clk1();
        check("fast_tick_b", 32'(tick8), 32'd1);
        check("fast_data_b", 32'(data8), 32'h04);
        clk1();
        check("fast_tick_c", 32'(tick8), 32'd1);
        check("fast_data_c", 32'(data8), 32'h08);
        speed = 2'd0;
        run_step("slow_gap", 4);
        check("slow_data", 32'(data8), 32'h10);
        clk1();
        check("mid_tick_a", 32'(tick8), 32'd0);
        clk1();
        check("mid_tick_b", 32'(tick8), 32'd0);
        speed = 2'd1;
        clk1();
        check("shrink_tick", 32'(tick8), 32'd1);
        check("shrink_data", 32'(data8), 32'h20);
        speed = 2'd2;

        // Comet, including tail flip and clipping at both ends
        mode = 2'b01;
        #1;
        check("comet_enter", 32'(data8), 32'h38);
        check("trail0_enter", 32'(data8t), 32'h20);
        for (int k = 0; k < 13; k++) begin
            clk1();
            check("comet_data", 32'(data8), 32'(comet_tbl[k]));
            check("comet_pos", 32'(pos8), 32'(comet_pos[k]));
            check("comet_dir", 32'(dir8), 32'(comet_dir[k]));
            check("trail0_data", 32'(data8t), 32'h1 << comet_pos[k]);
        end
        check("trail0_dir", 32'(dir8t), 32'd0);
        check("trail0_pos", 32'(pos8t), 32'd4);
        check("trail0_tick", 32'(tick8t), 32'd1);

        // Wrap chase
        mode = 2'b10;
        #1;
        check("wrap_enter", 32'(data8), 32'h10);
        clk1();
        clk1();
        clk1();
        check("wrap_top", 32'(data8), 32'h80);
        clk1();
        check("wrap_around", 32'(data8), 32'h01);
        check("wrap_dir", 32'(dir8), 32'd0);
        mode = 2'b00;
        for (int k = 0; k < 11; k++) clk1();
        check("pre_wrap_pos", 32'(pos8), 32'd3);
        check("pre_wrap_dir", 32'(dir8), 32'd1);
        mode = 2'b10;
        #1;
        check("wrap_dir1_enter", 32'(data8), 32'h08);
        clk1();
        check("wrap_dir1_pos", 32'(pos8), 32'd4);
        check("wrap_dir1_dir", 32'(dir8), 32'd0);
        check("wrap_dir1_data", 32'(data8), 32'h10);

        // Bar fill
        mode = 2'b11;
        #1;
        check("fill_enter", 32'(data8), 32'h1F);
        for (int k = 0; k < 11; k++) begin
            clk1();
            check("fill_data", 32'(data8), 32'(fill_tbl[k]));
        end

        // Enable freeze and mid-run reset
        mode = 2'b00;
        speed = 2'd0;
        #1;
        check("freeze_pre", 32'(data8), 32'h02);
        clk1();
        clk1();
        check("freeze_pre_tick", 32'(tick8), 32'd0);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk1();
            check("freeze_tick", 32'(tick8), 32'd0);
            check("freeze_data", 32'(data8), 32'h02);
            check("freeze_pos", 32'(pos8), 32'd1);
        end
        en = 1'b1;
        run_step("resume_gap", 2);
        check("resume_data", 32'(data8), 32'h04);
        clk1();
        clk1();
        rst = 1'b1;
        clk1();
        check("midrst_data", 32'(data8), 32'h01);
        check("midrst_pos", 32'(pos8), 32'd0);
        check("midrst_dir", 32'(dir8), 32'd0);
        check("midrst_tick", 32'(tick8), 32'd0);
        rst = 1'b0;
        run_step("post_rst_gap", 4);
        check("post_rst_data", 32'(data8), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
